// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// The slave modport is the cache's view; the master modport is the CPU plus memory.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [7:0]        WRITEDATA;
    logic [7:0]        READDATA;
    logic              BUSYWAIT;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-3:0] MEM_ADDRESS;
    logic [31:0]       MEM_WRITEDATA;
    logic [31:0]       MEM_READDATA;
    logic              MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache with byte CPU port and block-wide memory port.
// Misses run WRITEBACK (dirty victim) -> ALLOCATE -> UPDATE, then the held request hits in IDLE.
module dcache_ctrl #(
    parameter int NUM_BLOCKS = 8,
    parameter int ADDR_W     = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    dcache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t r_state, w_next;

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [NUM_BLOCKS-1:0] r_dirty;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [31:0]           r_data [NUM_BLOCKS];
    logic [31:0]           r_blk;

    logic [1:0]       w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_req;
    logic             w_hit;
    logic             w_wr_hit;
    logic             w_fill;

    assign w_off    = bus.ADDRESS[1:0];
    assign w_idx    = bus.ADDRESS[IDX_W+1:2];
    assign w_tag    = bus.ADDRESS[ADDR_W-1:IDX_W+2];
    assign w_req    = bus.READ | bus.WRITE;
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // READ+WRITE together counts as a store, so WRITE alone decides the store path
    assign w_wr_hit = (r_state == IDLE) && bus.WRITE && w_hit;
    assign w_fill   = (r_state == ALLOCATE) && !bus.MEM_BUSYWAIT;

    assign bus.BUSYWAIT = w_req && !((r_state == IDLE) && w_hit);
    assign bus.READDATA = r_data[w_idx][{w_off, 3'b000} +: 8];

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next            = r_state;
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = '0;
        bus.MEM_WRITEDATA = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit)
                    w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_ADDRESS   = {r_tag[w_idx], w_idx};
                bus.MEM_WRITEDATA = r_data[w_idx];
                if (!bus.MEM_BUSYWAIT) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                bus.MEM_READ    = 1'b1;
                bus.MEM_ADDRESS = {w_tag, w_idx};
                if (!bus.MEM_BUSYWAIT) w_next = UPDATE;
            end
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == UPDATE) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tags and data need no reset; a reset edge must not commit a pending fill or store
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (r_state == UPDATE) begin
                r_data[w_idx] <= r_blk;
                r_tag[w_idx]  <= w_tag;
            end else if (w_wr_hit) begin
                r_data[w_idx][{w_off, 3'b000} +: 8] <= bus.WRITEDATA;
            end
            if (w_fill) r_blk <= bus.MEM_READDATA;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench: a flat byte-memory model predicts load data, stall lengths and
// memory-bus traffic; a monitor and a memory responder compare against the cache.
module tb_dcache_ctrl;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    dcache_ctrl_if #(.ADDR_W(8)) bus ();

    dcache_ctrl #(.NUM_BLOCKS(8), .ADDR_W(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic       is_rd;
        logic [7:0] data;
        int         stall;
    } exp_t;
    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wb_t;

    exp_t       exp_q [$];
    wb_t        wb_q  [$];
    logic [5:0] rd_q  [$];

    logic [7:0]  ref_mem  [256];
    logic [31:0] mem_word [64];
    logic [7:0]  m_valid;
    logic [7:0]  m_dirty;
    logic [2:0]  m_tag [8];

    int n_chk = 0;
    int n_pass = 0;
    int rw_viol = 0;
    int idle_viol = 0;
    int nxt_k = 1;
    int nxt_j = 1;
    bit mon_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Memory holds the truth after reset; dirty cache contents are gone.
    task automatic model_reset();
        m_valid = '0;
        m_dirty = '0;
        for (int b = 0; b < 64; b++)
            for (int i = 0; i < 4; i++)
                ref_mem[b*4+i] = mem_word[b][i*8 +: 8];
    endtask

    task automatic issue(input logic [7:0] a, input logic rd, input logic wr,
                         input logic [7:0] wd, input int k, input int j);
        exp_t e;
        wb_t w;
        logic [2:0] idx, tg;
        logic hit;
        bit done;
        idx = a[4:2];
        tg  = a[7:5];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        e.stall = 0;
        if (!hit) begin
            e.stall = 2 + k;
            if (m_valid[idx] && m_dirty[idx]) begin
                w.a = {m_tag[idx], idx};
                w.d = {ref_mem[{m_tag[idx], idx, 2'd3}], ref_mem[{m_tag[idx], idx, 2'd2}],
                       ref_mem[{m_tag[idx], idx, 2'd1}], ref_mem[{m_tag[idx], idx, 2'd0}]};
                wb_q.push_back(w);
                e.stall += j;
            end
            rd_q.push_back({tg, idx});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        e.is_rd = rd && !wr;
        e.data  = ref_mem[a];
        exp_q.push_back(e);
        if (wr) begin
            ref_mem[a]   = wd;
            m_dirty[idx] = 1'b1;
        end
        nxt_k = k;
        nxt_j = j;
        bus.READ = rd;
        bus.WRITE = wr;
        bus.ADDRESS = a;
        bus.WRITEDATA = wd;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge CLK);
            if (!bus.BUSYWAIT) done = 1'b1;
        end
        if (!done) chk("req_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.READ = 1'b0;
        bus.WRITE = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    // CPU-side monitor: each completed request is matched against the scoreboard.
    initial begin
        int stall_cnt;
        exp_t e;
        stall_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!mon_en) stall_cnt = 0;
            else if (bus.READ || bus.WRITE) begin
                if (bus.BUSYWAIT) stall_cnt++;
                else if (exp_q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("stall_cycles", stall_cnt, e.stall);
                    if (e.is_rd) chk("readdata", {24'd0, bus.READDATA}, {24'd0, e.data});
                    stall_cnt = 0;
                end
            end
        end
    end

    // Memory responder: completes each access on its k-th (or j-th) request cycle.
    initial begin
        int cnt, lat;
        wb_t w;
        for (int b = 0; b < 64; b++) mem_word[b] = $urandom;
        mem_word[1] = 32'h44332211;
        bus.MEM_BUSYWAIT = 1'b1;
        bus.MEM_READDATA = '0;
        cnt = 0;
        lat = 1;
        forever begin
            @(negedge CLK);
            if (bus.MEM_READ && bus.MEM_WRITE) rw_viol++;
            if (!bus.MEM_READ && !bus.MEM_WRITE &&
                (bus.MEM_ADDRESS != '0 || bus.MEM_WRITEDATA != '0)) idle_viol++;
            if (bus.MEM_READ || bus.MEM_WRITE) begin
                if (cnt == 0) begin
                    if (bus.MEM_WRITE) begin
                        lat = nxt_j;
                        if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
                        else begin
                            w = wb_q.pop_front();
                            chk("wb_addr", {26'd0, bus.MEM_ADDRESS}, {26'd0, w.a});
                            chk("wb_data", bus.MEM_WRITEDATA, w.d);
                        end
                    end else begin
                        lat = nxt_k;
                        if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                        else chk("rd_addr", {26'd0, bus.MEM_ADDRESS}, {26'd0, rd_q.pop_front()});
                    end
                end
                cnt++;
                if (cnt >= lat) begin
                    bus.MEM_BUSYWAIT = 1'b0;
                    if (bus.MEM_WRITE) mem_word[bus.MEM_ADDRESS] = bus.MEM_WRITEDATA;
                    else bus.MEM_READDATA = mem_word[bus.MEM_ADDRESS];
                    cnt = 0;
                end else begin
                    bus.MEM_BUSYWAIT = 1'b1;
                    bus.MEM_READDATA = $urandom;
                end
            end else begin
                bus.MEM_BUSYWAIT = 1'b1;
                bus.MEM_READDATA = $urandom;
                cnt = 0;
            end
        end
    end

    initial begin
        logic [2:0] tg, idx;
        logic [1:0] off;
        int op;
        RESET = 1'b1;
        bus.READ = 1'b0;
        bus.WRITE = 1'b0;
        bus.ADDRESS = '0;
        bus.WRITEDATA = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        model_reset();

        @(negedge CLK);
        chk("rst_mem_read", {31'd0, bus.MEM_READ}, 32'd0);
        chk("rst_mem_write", {31'd0, bus.MEM_WRITE}, 32'd0);
        chk("rst_mem_addr", {26'd0, bus.MEM_ADDRESS}, 32'd0);
        chk("rst_mem_wdata", bus.MEM_WRITEDATA, 32'd0);
        chk("rst_busywait_idle", {31'd0, bus.BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;

        issue(8'h05, 1'b1, 1'b0, 8'h00, 3, 1);   // cold miss, 0x22 after 5 stalls
        issue(8'h06, 1'b1, 1'b0, 8'h00, 1, 1);
        issue(8'h07, 1'b0, 1'b1, 8'hAA, 1, 1);
        issue(8'h07, 1'b1, 1'b0, 8'h00, 1, 1);
        issue(8'h25, 1'b1, 1'b0, 8'h00, 2, 3);   // dirty eviction of block 0x01
        issue(8'h05, 1'b1, 1'b0, 8'h00, 2, 1);   // clean eviction
        issue(8'h06, 1'b1, 1'b1, 8'h5C, 1, 1);   // READ+WRITE acts as store
        issue(8'h06, 1'b1, 1'b0, 8'h00, 1, 1);
        issue(8'h26, 1'b1, 1'b0, 8'h00, 1, 2);   // proves the 0x5C line was dirty

        // Reset during ALLOCATE abandons the fill.
        mon_en = 1'b0;
        rd_q.push_back(6'h20);
        nxt_k = 4;
        bus.READ = 1'b1;
        bus.ADDRESS = 8'h80;
        @(negedge CLK);
        chk("rm_idle_miss_busy", {31'd0, bus.BUSYWAIT}, 32'd1);
        @(negedge CLK);
        chk("rm_alloc_mem_read", {31'd0, bus.MEM_READ}, 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("rm_mem_read_dropped", {31'd0, bus.MEM_READ}, 32'd0);
        chk("rm_still_miss", {31'd0, bus.BUSYWAIT}, 32'd1);
        bus.READ = 1'b0;
        model_reset();
        @(posedge CLK);
        #1 mon_en = 1'b1;
        issue(8'h80, 1'b1, 1'b0, 8'h00, 2, 1);

        for (int n = 0; n < 60; n++) begin
            tg  = 3'($urandom_range(0, 3));
            idx = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            op  = int'($urandom_range(0, 2));
            issue({tg, idx, off}, op != 1, op != 0, 8'($urandom),
                  int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) idle();
        end

        idle();
        repeat (3) @(posedge CLK);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("wb_queue_drained", wb_q.size(), 32'd0);
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        chk("mem_rw_exclusive", rw_viol, 32'd0);
        chk("mem_idle_zero", idle_viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back data cache sitting between the CPU datapath (serving the `lwd`/`lwi`/`swd`/`swi` memory opcodes) and the word-wide data memory. It is a byte-addressed CPU port with a stall line (`BUSYWAIT`) that freezes the PC and register-file writes on a miss. It runs a refill/write-back FSM against a block-wide memory port with its own busy handshake.

## Interface

Parameters:
- `NUM_BLOCKS`, 8: cache lines; the index is `log2(NUM_BLOCKS)` bits.
- `ADDR_W`, 8: CPU byte-address width. The tag is `ADDR_W - 2 - log2(NUM_BLOCKS)` bits.

Clocking: one clock; reset is synchronous and active-high.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `READ`  in  1  CPU load request, held until `BUSYWAIT` is low at an edge.
- `WRITE`  in  1  CPU store request, same holding rule as `READ`.
- `ADDRESS`  in  `ADDR_W`  byte address; `[1:0]` is the offset, then the index, then the tag.
- `WRITEDATA`  in  8  store byte.
- `READDATA`  out  8  load byte; combinational from the array.
- `BUSYWAIT`  out  1  CPU stall request.
- `MEM_READ`  out  1  block fetch request.
- `MEM_WRITE`  out  1  block write-back request.
- `MEM_ADDRESS`  out  `ADDR_W-2`  block address, tag plus index.
- `MEM_WRITEDATA`  out  32  victim block; byte 0 is in `[7:0]`.
- `MEM_READDATA`  in  32  fetched block.
- `MEM_BUSYWAIT`  in  1  memory busy. The cache treats an access as complete at the first edge where its request is high and `MEM_BUSYWAIT` is low.

## Operation

Storage per line: `valid`, `dirty`, `tag`, and a 32-bit data block.

Hit: `hit = valid[idx] & (tag[idx] == ADDRESS tag)`.

`BUSYWAIT = (READ | WRITE) & !(state == IDLE & hit)`.

If `READ` and `WRITE` are both high, the request is treated as a write.

FSM states: `IDLE`, `WRITEBACK`, `ALLOCATE`, `UPDATE`.
- **IDLE**
  - Read hit: `READDATA` = selected byte; no state change.
  - Write hit: at the edge, write the byte at the offset and set `dirty`.
  - Miss with a clean or invalid victim: go to `ALLOCATE`.
  - Miss with a valid, dirty victim: go to `WRITEBACK`.
  - No request: remain in `IDLE`; no array change.
- **WRITEBACK**
  - `MEM_WRITE=1`, `MEM_ADDRESS={victim tag, idx}`, `MEM_WRITEDATA=victim block`.
  - On an edge with `MEM_BUSYWAIT=0`: go to `ALLOCATE`.
- **ALLOCATE**
  - `MEM_READ=1`, `MEM_ADDRESS={req tag, idx}`.
  - On an edge with `MEM_BUSYWAIT=0`: latch `MEM_READDATA` into a block buffer and go to `UPDATE`.
- **UPDATE**
  - Write the buffer into `data[idx]`; set `tag[idx]`, `valid=1`, `dirty=0`.
  - Go to `IDLE`, where the held request now hits. A store completes there and sets `dirty`.
- In every state, `MEM_READ` and `MEM_WRITE` are never high together.
- Outside their states, `MEM_*` outputs are 0.
- `ADDRESS` must be held stable while `BUSYWAIT=1`. Changes during a miss are a CPU protocol violation, and behaviour is undefined.

## Timing

After the reset edge:
- state is `IDLE`;
- all `valid` and `dirty` bits are 0; tags and data are don't-care;
- `MEM_READ=0`, `MEM_WRITE=0`, `MEM_ADDRESS=0`, `MEM_WRITEDATA=0`;
- `BUSYWAIT` follows the formula, so any request is a miss.

Hit latency: 0 stall cycles. The load byte is valid in the same cycle, and the store is committed at that cycle's edge.

Clean miss, with memory completing on the k-th request cycle (k≥1): `BUSYWAIT` is high for 1 + k + 1 cycles (IDLE miss, ALLOCATE×k, UPDATE). The request completes in the following IDLE cycle.

Dirty miss with write-back taking j cycles: add j stall cycles.

Reset mid-miss:
- At the reset edge, return to `IDLE` and drop `MEM_READ`/`MEM_WRITE`.
- The in-flight memory access is abandoned and no array update occurs.
- Dirty data is lost.

A write hit to a dirty line keeps `dirty=1`. A read miss that evicts a clean line produces no `MEM_WRITE`.

## Test plan

1. **Read after reset.** Reset, then `READ` at address `0x05`, with memory returning `0x44332211` at k=3. Required: `BUSYWAIT` high for 5 cycles; `MEM_ADDRESS=0x01`; `READDATA=0x22` in the completing cycle.
2. **Read and write hit.** Next cycle, read `0x06`. Required: `BUSYWAIT=0` and `READDATA=0x33`. Then write `0xAA` to `0x07`. Required: no stall, and a later read of `0x07` returns `0xAA`.
3. **Dirty eviction.** Read `0x25`, which has the same index and a different tag. Required: `MEM_WRITE` with `MEM_ADDRESS=0x01` and `MEM_WRITEDATA=0xAA332211`. After that, `MEM_READ` with `MEM_ADDRESS=0x09`. `MEM_READ` and `MEM_WRITE` are never high together.
4. **Clean eviction.** Evict a clean line. Required: no `MEM_WRITE` cycle, and the stall is exactly 2 + k cycles.
5. **Reset mid-miss.** Assert `RESET` during `ALLOCATE`. Required: next cycle the FSM is in `IDLE` with `MEM_READ=0`, and the line is still invalid, so a re-read of the same address misses again.
6. **Simultaneous request.** Hold `READ=1` and `WRITE=1` with `WRITEDATA=0x5C` on a hit. Required: the byte is stored, the line becomes dirty, and a subsequent read returns `0x5C`.
